// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter and sequencer in front of the
// single-ported DataMemory. Each grant produces one memory access cycle
// followed by a one-cycle response pulse to the granted port.
module dm_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // requester side
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    // DataMemory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_t;

    state_t state_q, state_d;

    // Port index of the most recent grant; 1 at reset so port 0 wins the first tie.
    logic last_grant_q, last_grant_d;

    // Request captured at the handshake and replayed during ACCESS.
    logic              acc_port_q,  acc_port_d;
    logic              acc_write_q, acc_write_d;
    logic [ADDR_W-1:0] acc_addr_q,  acc_addr_d;
    logic [DATA_W-1:0] acc_wdata_q, acc_wdata_d;

    // Response registers.
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    // Arbitration winner (one-hot or zero) and the resulting handshake.
    logic [1:0] win;
    logic [1:0] hs;
    logic       hs_any;
    logic       hs_port;

    // Round-robin winner: a lone valid port wins, a tie goes to the port not granted last.
    always_comb begin
        win = 2'b00;
        case (req_valid)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_grant_q ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    assign hs      = req_valid & req_ready;
    assign hs_any  = |hs;
    assign hs_port = hs[1];

    // State register; reset forces IDLE immediately, which also drops mem_write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE moves to ACCESS on a handshake, ACCESS always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = hs_any ? StAccess : StIdle;
            StAccess: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: grant in IDLE, drive the memory only during ACCESS.
    always_comb begin
        req_ready = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            StIdle: begin
                // Ready is combinational, but held low for the whole reset assertion.
                req_ready = rst ? 2'b00 : win;
            end
            StAccess: begin
                mem_addr  = acc_addr_q;
                mem_wdata = acc_wdata_q;
                mem_read  = ~acc_write_q;
                mem_write = acc_write_q;
            end
            default: begin
                req_ready = 2'b00;
            end
        endcase
    end

    // Capture the winning request and update the round-robin pointer on a handshake.
    always_comb begin
        acc_port_d   = acc_port_q;
        acc_write_d  = acc_write_q;
        acc_addr_d   = acc_addr_q;
        acc_wdata_d  = acc_wdata_q;
        last_grant_d = last_grant_q;
        if (hs_any) begin
            acc_port_d   = hs_port;
            acc_write_d  = req_write[hs_port];
            acc_addr_d   = hs_port ? req_addr1  : req_addr0;
            acc_wdata_d  = hs_port ? req_wdata1 : req_wdata0;
            last_grant_d = hs_port;
        end
    end

    // Request latch and grant pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_port_q   <= 1'b0;
            acc_write_q  <= 1'b0;
            acc_addr_q   <= '0;
            acc_wdata_q  <= '0;
            last_grant_q <= 1'b1;
        end else begin
            acc_port_q   <= acc_port_d;
            acc_write_q  <= acc_write_d;
            acc_addr_q   <= acc_addr_d;
            acc_wdata_q  <= acc_wdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Response next-state: pulse after ACCESS; mem_rdata is only looked at during a load.
    always_comb begin
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        if (state_q == StAccess) begin
            rsp_valid_d = acc_port_q ? 2'b10 : 2'b01;
            rsp_rdata_d = acc_write_q ? '0 : mem_rdata;
        end
    end

    // Response registers; rsp_rdata holds between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    wire  [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    // Stand-in DataMemory (64 words, aliased on the low address bits).
    logic [31:0] dmem [64];
    assign mem_rdata = mem_read ? dmem[mem_addr[5:0]] : 'z;
    always @(posedge clk) if (mem_write) dmem[mem_addr[5:0]] <= mem_wdata;

    // Reference model: expected memory contents and the pending transaction.
    logic [31:0] ref_mem [64];
    logic        m_busy;
    int          m_port;
    int          m_last;
    logic        m_write;
    logic [31:0] m_addr, m_data, m_rdata;
    logic [1:0]  m_rsp;
    // Values sampled by the last cyc() call.
    logic [1:0]  s_rsp;
    logic [31:0] s_rdata;

    dm_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_wdata0(req_wdata0),
        .req_wdata1(req_wdata1),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_rsp   = 2'b00;
        m_rdata = 32'h0;
        m_last  = 1;
    endtask

    // One lone valid port wins; on a tie the port not granted last wins.
    function automatic logic [1:0] winner(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 1) ? 2'b01 : 2'b10;
        return v;
    endfunction

    task automatic set_port(input int p, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
        req_write[p] = w;
        if (p == 0) begin
            req_addr0 = a; req_wdata0 = d;
        end else begin
            req_addr1 = a; req_wdata1 = d;
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'h0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // Called 1 time unit after a rising edge with inputs already driven; checks
    // this cycle's outputs, advances one edge, updates the model.
    task automatic cyc(output logic [1:0] hs);
        logic [1:0]  er;
        logic [31:0] ea, ed;
        logic        erd, ewr;
        #3;
        er  = m_busy ? 2'b00 : winner(req_valid, m_last);
        ea  = m_busy ? m_addr : 32'h0;
        ed  = m_busy ? m_data : 32'h0;
        erd = m_busy && !m_write;
        ewr = m_busy && m_write;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("mem_read", 32'(mem_read), 32'(erd));
        chk("mem_write", 32'(mem_write), 32'(ewr));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        chk("rsp_rdata", rsp_rdata, m_rdata);
        s_rsp   = rsp_valid;
        s_rdata = rsp_rdata;
        hs      = er;
        @(posedge clk);
        if (m_busy) begin
            m_rsp   = (m_port == 1) ? 2'b10 : 2'b01;
            m_rdata = m_write ? 32'h0 : ref_mem[m_addr[5:0]];
            if (m_write) ref_mem[m_addr[5:0]] = m_data;
        end else begin
            m_rsp = 2'b00;
        end
        if (hs != 2'b00) begin
            m_busy  = 1'b1;
            m_port  = hs[1] ? 1 : 0;
            m_last  = m_port;
            m_write = req_write[m_port];
            m_addr  = (m_port == 1) ? req_addr1  : req_addr0;
            m_data  = (m_port == 1) ? req_wdata1 : req_wdata0;
        end else begin
            m_busy = 1'b0;
        end
        #1;
    endtask

    // Issue one request on port p and hold it until granted (bounded).
    task automatic do_req(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
        logic [1:0] hs;
        bit got;
        got = 0;
        set_port(p, w, a, d);
        req_valid[p] = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            cyc(hs);
            if (hs[p]) got = 1;
        end
        req_valid[p] = 1'b0;
        chk("grant_timeout", 32'(got), 32'h1);
    endtask

    task automatic idle(input int n);
        logic [1:0] hs;
        for (int i = 0; i < n; i++) cyc(hs);
    endtask

    initial begin
        logic [1:0]  hs;
        logic [31:0] a;
        bit          act [2];
        int          grants, prev;

        req_valid = 2'b00; req_write = 2'b00;
        req_addr0 = 32'h0; req_addr1 = 32'h0; req_wdata0 = 32'h0; req_wdata1 = 32'h0;
        for (int i = 0; i < 64; i++) begin
            dmem[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        model_reset();

        // Power-on reset: values appear without a clock edge; ready stays low.
        #1 rst = 1'b1;
        req_valid = 2'b11;
        #1 rst_chk("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // First tie after reset goes to port 0.
        set_port(0, 1'b0, 32'h4, 32'h0);
        set_port(1, 1'b0, 32'h8, 32'h0);
        cyc(hs);
        chk("first_tie", 32'(hs), 32'h1);
        req_valid = 2'b00;
        idle(3);

        // Store then load on port 0.
        do_req(0, 1'b1, 32'h0, 32'hAAAA_AAAA);
        idle(2);
        chk("store_rsp_valid", 32'(s_rsp), 32'h1);
        chk("store_rsp_rdata", s_rdata, 32'h0);
        do_req(0, 1'b0, 32'h0, 32'h1234_5678);
        idle(2);
        chk("load_rsp_valid", 32'(s_rsp), 32'h1);
        chk("load_rsp_rdata", s_rdata, 32'hAAAA_AAAA);

        // Contention: both continuously valid for 8 grants; must alternate.
        set_port(0, 1'b1, 32'h0F, 32'h100);
        set_port(1, 1'b0, 32'h10, 32'h0);
        req_valid = 2'b11;
        grants = 0;
        prev   = -1;
        for (int c = 0; c < 40 && grants < 8; c++) begin
            cyc(hs);
            if (hs != 2'b00) begin
                if (prev >= 0) chk("alternate", hs[1] ? 32'h1 : 32'h0, 32'(1 - prev));
                prev = hs[1] ? 1 : 0;
                grants++;
                if (hs[0]) req_wdata0 = req_wdata0 + 32'h1;
            end
        end
        req_valid = 2'b00;
        chk("contention_grants", 32'(grants), 32'd8);
        idle(3);

        // Idle bus with memory read data floating; rsp_rdata must hold.
        do_req(1, 1'b0, 32'h0, 32'h0);
        idle(12);
        chk("idle_hold", s_rdata, 32'hAAAA_AAAA);

        // Reset while a store is in ACCESS: the store must not commit.
        do_req(0, 1'b1, 32'h0F, 32'h0000_000F);
        idle(3);
        do_req(0, 1'b1, 32'h0F, 32'hDEAD_BEEF);
        #1 chk("pre_rst_write", 32'(mem_write), 32'h1);
        rst = 1'b1;
        #1 rst_chk("mid_access");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        do_req(0, 1'b0, 32'h0F, 32'h0);
        idle(2);
        chk("aborted_store_rsp", 32'(s_rsp), 32'h1);
        chk("aborted_store_data", s_rdata, 32'h0000_000F);

        // Cancel: port 1 valid only while port 0 is in ACCESS.
        do_req(0, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 32'h20, 32'h5555_5555);
        req_valid[1] = 1'b1;
        cyc(hs);
        chk("cancel_no_grant", 32'(hs), 32'h0);
        req_valid[1] = 1'b0;
        idle(5);
        chk("cancel_no_write", ref_mem[6'h20], 32'h0);

        // Random traffic with holds, cancels and aliasing addresses.
        act[0] = 0; act[1] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && $urandom_range(1, 0) == 1) begin
                    act[p] = 1;
                    a = $urandom;
                    a[5:0] = 6'($urandom_range(7, 0));
                    set_port(p, 1'($urandom_range(1, 0)), a, $urandom);
                end else if (act[p] && $urandom_range(15, 0) == 0) begin
                    act[p] = 0;
                end
                req_valid[p] = act[p];
            end
            cyc(hs);
            for (int p = 0; p < 2; p++) if (hs[p]) act[p] = 0;
        end
        req_valid = 2'b00;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
